// File: rtl/mul_operand_sequencer_pkg.sv
// ============================================================================
// Module      : mul_seq_pkg
// Description : Shared types, widths and helpers for the multiplier operand
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_seq_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } seq_state_t;

    localparam int OPERAND_BYTES = 4;
    localparam int RESULT_BYTES  = 4;
    localparam int BYTE_W        = 8;
    localparam int OPERAND_W     = 16;
    localparam int PRODUCT_W     = 32;

    localparam logic [1:0] IDX_LAST_OPERAND = 2'(OPERAND_BYTES - 1);
    localparam logic [1:0] IDX_LAST_RESULT  = 2'(RESULT_BYTES - 1);

    // Little-endian byte select: idx 0 returns P[7:0].
    function automatic logic [BYTE_W-1:0] result_byte(
        input logic [PRODUCT_W-1:0] p,
        input logic [1:0]           idx
    );
        return p[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage : mul_seq_pkg

`default_nettype wire

// File: rtl/mul_operand_sequencer_if.sv
// ============================================================================
// Module      : mul_operand_sequencer_if
// Description : Byte streams, multiplier operand/product bus and status of
//               the operand sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_operand_sequencer_if;
    import mul_seq_pkg::*;

    logic [BYTE_W-1:0]    din;
    logic                 din_valid;
    logic                 din_ready;
    logic [OPERAND_W-1:0] mul_a;
    logic [OPERAND_W-1:0] mul_b;
    logic [PRODUCT_W-1:0] mul_p;
    logic [BYTE_W-1:0]    dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 busy;
    logic [15:0]          op_count;

    // Environment side: byte source, byte sink and multiplier.
    modport master (
        output din, din_valid, dout_ready, mul_p,
        input  din_ready, mul_a, mul_b, dout, dout_valid, busy, op_count
    );

    // Sequencer side.
    modport slave (
        input  din, din_valid, dout_ready, mul_p,
        output din_ready, mul_a, mul_b, dout, dout_valid, busy, op_count
    );

endinterface : mul_operand_sequencer_if

`default_nettype wire

// File: rtl/mul_operand_sequencer.sv
// ============================================================================
// Module      : mul_operand_sequencer
// Description : Assembles two signed 16-bit operands from a byte stream,
//               waits out the multiplier latency and streams the product back.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_operand_sequencer
    import mul_seq_pkg::*;
#(
    parameter int MUL_LATENCY = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    mul_operand_sequencer_if.slave  bus
);

    localparam logic [3:0] C_LAT_INIT = 4'(MUL_LATENCY);

    seq_state_t           r_state;
    logic [1:0]           r_idx;
    logic [3:0]           r_lat;
    logic [OPERAND_W-1:0] r_a;
    logic [OPERAND_W-1:0] r_b;
    logic [PRODUCT_W-1:0] r_result;
    logic [15:0]          r_op_count;
    logic                 r_din_ready;
    logic                 r_dout_valid;
    logic                 r_busy;

    logic                 w_din_fire;
    logic                 w_dout_fire;

    assign w_din_fire  = bus.din_valid & r_din_ready;
    assign w_dout_fire = r_dout_valid & bus.dout_ready;

    // Status outputs are flops updated alongside the state, so no input
    // handshake signal reaches them combinationally.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state      <= LOAD;
            r_idx        <= 2'd0;
            r_lat        <= 4'd0;
            r_a          <= '0;
            r_b          <= '0;
            r_result     <= '0;
            r_op_count   <= 16'd0;
            r_din_ready  <= 1'b1;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_din_fire) begin
                        case (r_idx)
                            2'd0:    r_a[BYTE_W-1:0]         <= bus.din;
                            2'd1:    r_a[OPERAND_W-1:BYTE_W] <= bus.din;
                            2'd2:    r_b[BYTE_W-1:0]         <= bus.din;
                            default: r_b[OPERAND_W-1:BYTE_W] <= bus.din;
                        endcase
                        if (r_idx == IDX_LAST_OPERAND) begin
                            r_state     <= WAIT;
                            r_idx       <= 2'd0;
                            r_lat       <= C_LAT_INIT;
                            r_din_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                WAIT: begin
                    // One extra edge after the count expires lets the product
                    // of the final operand byte settle before capture.
                    if (r_lat == 4'd0) begin
                        r_result     <= bus.mul_p;
                        r_state      <= SEND;
                        r_idx        <= 2'd0;
                        r_dout_valid <= 1'b1;
                    end else begin
                        r_lat <= r_lat - 4'd1;
                    end
                end

                SEND: begin
                    if (w_dout_fire) begin
                        if (r_idx == IDX_LAST_RESULT) begin
                            r_state      <= LOAD;
                            r_idx        <= 2'd0;
                            r_op_count   <= r_op_count + 16'd1;
                            r_dout_valid <= 1'b0;
                            r_din_ready  <= 1'b1;
                            r_busy       <= 1'b0;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end
                end

                default: begin
                    r_state      <= LOAD;
                    r_idx        <= 2'd0;
                    r_din_ready  <= 1'b1;
                    r_dout_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.din_ready  = r_din_ready;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = r_busy;
    assign bus.mul_a      = r_a;
    assign bus.mul_b      = r_b;
    assign bus.op_count   = r_op_count;
    assign bus.dout       = result_byte(r_result, r_idx);

endmodule : mul_operand_sequencer

`default_nettype wire

// File: tb/tb_mul_operand_sequencer.sv
// ============================================================================
// Module      : tb_mul_operand_sequencer
// Description : Directed scoreboard bench for the multiplier operand sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_operand_sequencer;
    import mul_seq_pkg::*;

    localparam int CLK_HALF   = 5;
    localparam int CLK_PERIOD = 2 * CLK_HALF;
    localparam int WAIT_MAX   = 50;

    logic wb_clk_i   = 1'b0;
    logic wb_rst_n_i = 1'b0;

    always #CLK_HALF wb_clk_i = ~wb_clk_i;

    mul_operand_sequencer_if if1 ();
    mul_operand_sequencer_if if3 ();

    mul_operand_sequencer #(.MUL_LATENCY(1)) u_dut1 (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .bus        (if1.slave)
    );

    mul_operand_sequencer #(.MUL_LATENCY(3)) u_dut3 (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_n_i (wb_rst_n_i),
        .bus        (if3.slave)
    );

    function automatic logic [31:0] prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        return 32'(sa * sb);
    endfunction

    // Multiplier models: one register stage, and a three-stage pipeline.
    logic [31:0] p1, p3_s0, p3_s1, p3_s2;
    always @(posedge wb_clk_i) begin
        p1    <= prod(if1.mul_a, if1.mul_b);
        p3_s0 <= prod(if3.mul_a, if3.mul_b);
        p3_s1 <= p3_s0;
        p3_s2 <= p3_s1;
    end
    assign if1.mul_p = p1;
    assign if3.mul_p = p3_s2;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  sb3_q[$];
    time         t_e0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_din_ready"},  32'(if1.din_ready),  32'd1);
        chk({tag, "_dout_valid"}, 32'(if1.dout_valid), 32'd0);
        chk({tag, "_dout"},       32'(if1.dout),       32'd0);
        chk({tag, "_busy"},       32'(if1.busy),       32'd0);
        chk({tag, "_mul_a"},      32'(if1.mul_a),      32'd0);
        chk({tag, "_mul_b"},      32'(if1.mul_b),      32'd0);
        chk({tag, "_op_count"},   32'(if1.op_count),   32'd0);
    endtask

    // Called at a negedge; returns at a negedge after the 4th handshake plus
    // one cycle of ignored din_valid while the block is in WAIT.
    task automatic send_op(input logic [15:0] a, input logic [15:0] b, input int gap);
        logic [31:0] p;
        logic [7:0]  bytes_in [4];
        int          n;
        p = prod(a, b);
        for (int k = 0; k < 4; k++) sb_q.push_back(p[k*8 +: 8]);
        bytes_in[0] = a[7:0];
        bytes_in[1] = a[15:8];
        bytes_in[2] = b[7:0];
        bytes_in[3] = b[15:8];
        for (int k = 0; k < 4; k++) begin
            if (gap > 0 && k > 0) begin
                if1.din       = 8'hA5;
                if1.din_valid = 1'b0;
                repeat (gap) @(negedge wb_clk_i);
            end
            if1.din       = bytes_in[k];
            if1.din_valid = 1'b1;
            n = 0;
            while (!if1.din_ready && n < WAIT_MAX) begin
                @(negedge wb_clk_i);
                n++;
            end
            chk("din_ready_wait", 32'(if1.din_ready), 32'd1);
            @(posedge wb_clk_i);
            t_e0 = $time;
            @(negedge wb_clk_i);
        end
        // A byte offered outside LOAD must not be consumed.
        if1.din       = 8'hEE;
        if1.din_valid = 1'b1;
        chk("busy_in_wait", 32'(if1.busy), 32'd1);
        @(negedge wb_clk_i);
        if1.din_valid = 1'b0;
        chk("mul_a_hold", 32'(if1.mul_a), 32'(a));
        chk("mul_b_hold", 32'(if1.mul_b), 32'(b));
    endtask

    task automatic recv_op(input int stall_k, input int stall_n, input logic [15:0] exp_cnt);
        int         n;
        logic [7:0] held;
        logic [7:0] exp_b;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!if1.dout_valid && n < WAIT_MAX) begin
                @(negedge wb_clk_i);
                n++;
            end
            chk("dout_valid_wait", 32'(if1.dout_valid), 32'd1);
            if (k == 0)
                chk("capture_latency", 32'($time - t_e0), 32'(2 * CLK_PERIOD + CLK_HALF));
            chk("no_overlap_din_ready", 32'(if1.din_ready), 32'd0);
            if (k == stall_k) begin
                held = if1.dout;
                if1.dout_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge wb_clk_i);
                    chk("stall_valid", 32'(if1.dout_valid), 32'd1);
                    chk("stall_hold",  32'(if1.dout),       32'(held));
                end
            end
            exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            chk("dout_byte", 32'(if1.dout), 32'(exp_b));
            if1.dout_ready = 1'b1;
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if1.dout_ready = 1'b0;
        end
        chk("din_ready_after_send",  32'(if1.din_ready),  32'd1);
        chk("dout_valid_after_send", 32'(if1.dout_valid), 32'd0);
        chk("busy_after_send",       32'(if1.busy),       32'd0);
        chk("op_count",              32'(if1.op_count),   32'(exp_cnt));
    endtask

    initial begin
        int          n;
        logic [31:0] p3;
        logic [7:0]  b3 [4];

        if1.din = 8'h00; if1.din_valid = 1'b0; if1.dout_ready = 1'b0;
        if3.din = 8'h00; if3.din_valid = 1'b0; if3.dout_ready = 1'b0;
        wb_rst_n_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check_reset_vals("reset");
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        // Latency-1 operations, back to back.
        send_op(16'h0003, 16'hFFFE, 0); recv_op(-1, 0, 16'd1);
        send_op(16'h8000, 16'h8000, 0); recv_op(-1, 0, 16'd2);
        send_op(16'h7FFF, 16'h8000, 0); recv_op(2, 5, 16'd3);
        send_op(16'h1234, 16'hFEDC, 2); recv_op(-1, 0, 16'd4);

        // Latency-3 instance with the sink always ready.
        p3 = prod(16'h1234, 16'h0010);
        for (int k = 0; k < 4; k++) sb3_q.push_back(p3[k*8 +: 8]);
        b3[0] = 8'h34; b3[1] = 8'h12; b3[2] = 8'h10; b3[3] = 8'h00;
        if3.dout_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if3.din       = b3[k];
            if3.din_valid = 1'b1;
            @(posedge wb_clk_i);
            t_e0 = $time;
            @(negedge wb_clk_i);
        end
        if3.din_valid = 1'b0;
        n = 0;
        while (!if3.dout_valid && n < WAIT_MAX) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("lat3_capture", 32'($time - t_e0), 32'(4 * CLK_PERIOD + CLK_HALF));
        for (int k = 0; k < 4; k++) begin
            chk("lat3_dout", 32'(if3.dout), 32'((sb3_q.size() > 0) ? sb3_q.pop_front() : 8'hxx));
            @(negedge wb_clk_i);
        end
        chk("lat3_op_count",  32'(if3.op_count),  32'd1);
        chk("lat3_din_ready", 32'(if3.din_ready), 32'd1);

        // Reset after two operand bytes.
        if1.din = 8'h11; if1.din_valid = 1'b1;
        @(posedge wb_clk_i); @(negedge wb_clk_i);
        if1.din = 8'h22;
        @(posedge wb_clk_i); @(negedge wb_clk_i);
        if1.din_valid = 1'b0;
        chk("partial_mul_a", 32'(if1.mul_a), 32'h0000_2211);
        #2 wb_rst_n_i = 1'b0;
        #1 check_reset_vals("rst_load");
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        // Reset while streaming the result.
        send_op(16'h0102, 16'h0003, 0);
        n = 0;
        while (!if1.dout_valid && n < WAIT_MAX) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("send_reached", 32'(if1.dout_valid), 32'd1);
        #2 wb_rst_n_i = 1'b0;
        #1 check_reset_vals("rst_send");
        sb_q.delete();
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        send_op(16'd5, 16'd7, 0); recv_op(-1, 0, 16'd1);

        // Counter wrap.
        force u_dut1.r_op_count = 16'hFFFF;
        @(negedge wb_clk_i);
        release u_dut1.r_op_count;
        @(negedge wb_clk_i);
        chk("op_count_preload", 32'(if1.op_count), 32'h0000_FFFF);
        send_op(16'hFFFF, 16'hFFFF, 0); recv_op(-1, 0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mul_operand_sequencer

`default_nettype wire
